fp_norm_shift: RTL and testbench
================================

// Module: fp_norm_shift
// PURPOSE
//  Normalisation stage of the float datapath. Sits directly downstream of the
//  leading-zero counter (lzv) and consumes its count for the same operand.
//  Left-shifts the unnormalised 24-bit mantissa so bit 23 is 1, and adjusts the
//  biased exponent to match. Clamps to subnormal form on exponent underflow.
//  Two-stage pipeline with a valid/ready handshake on both sides.
// PARAMETERS
//  MW  24  mantissa width, hidden bit included
//  EW  8   biased exponent width
//  LZW 5   leading-zero count width; holds 0..MW
// PORTS
//  clk        in   1    clock, rising edge
//  rst_n      in   1    asynchronous reset, active low
//  in_valid   in   1    input beat valid
//  in_ready   out  1    stage accepts input this cycle
//  in_mant    in   MW   unnormalised mantissa
//  in_exp     in   EW   biased exponent of in_mant
//  in_lz      in   LZW  leading zeros of in_mant from lzv (MW means zero)
//  out_valid  out  1    output beat valid
//  out_ready  in   1    downstream accepts output
//  out_mant   out  MW   normalised mantissa
//  out_exp    out  EW   adjusted biased exponent
//  out_zero   out  1    result is zero
//  out_uf     out  1    exponent underflowed; result is subnormal
// BEHAVIOUR
//  Reset (rst_n=0, async): both stage valids=0; out_valid=0; out_mant/out_exp=0;
//   out_zero/out_uf=0. in_ready=1 once reset is released.
//  Handshake: a beat transfers when valid&ready are high on a rising clk edge.
//   Stage S2 advances when ~s2_v | out_ready. S1 advances when ~s1_v | S2 advances.
//   in_ready is that S1-advance term. It is combinational on out_ready; no
//   combinational path runs from in_valid.
//  Latency: exactly 2 cycles, in-transfer to out_valid, with no stall. Sustained
//   throughput is 1 beat per cycle when out_ready=1.
//  Stalls: while out_valid & ~out_ready, all out_* hold stable. Beats are never
//   dropped or duplicated. Order is preserved. The pipeline holds at most 2 beats.
//  S1 (shift decision), with e=in_exp and n=in_lz:
//   n==MW            -> sh=0, exp=0, zero=1, uf=0
//   e>n              -> sh=n, exp=e-n, uf=0
//   e<=n and e>=1    -> sh=e-1, exp=0, uf=1 (subnormal)
//   e==0             -> sh=0, exp=0, uf=1 (already subnormal)
//   Compare e>n at EW+1 bits; no wrap-around is allowed.
//  S2: out_mant = s1_mant << sh, zero-filled, truncated to MW bits. Flags pass
//   through.
//  in_lz > MW is illegal. Behaviour is then undefined, but the block must not
//   lock up; the bench asserts this never occurs.
//  Simultaneous S2 drain and S1 fill in one cycle is legal and must not bubble.
//  Reset mid-operation: all in-flight beats are discarded and no output is emitted.
// STRUCTURE
//  Package fp_pkg: MW/EW/LZW localparams, EXP_BIAS=127, and a norm_beat_t
//   struct {mant, exp, zero, uf}.
//  One sub-module: fp_lshift, a combinational log2(MW)-level barrel left shifter
//   (MW data, LZW shift amount), instanced in S2.
//  Top level: two pipeline registers, the S1 decision logic, and handshake logic.
// TESTING
//  1 mant=24'h000400, exp=100, lz=13, out_ready=1 -> after 2 clk:
//    out_mant=24'h800000, out_exp=87, zero=0, uf=0.
//  2 mant=24'h000001, exp=5, lz=23 -> out_mant=24'h000010 (shift 4), exp=0, uf=1.
//  3 mant=0, exp=77, lz=24 -> out_mant=0, exp=0, zero=1.
//  4 mant=24'hC00000, exp=255, lz=0 -> unchanged; out_exp=255.
//  5 Stream 1..40 (exp=50), lz per value, out_ready=LFSR ~50% -> in-order, no
//    loss, out_* stable while stalled, in_ready=0 only when both stages are full.
//  6 Two beats in flight, pulse rst_n low for 3 ps mid-cycle -> out_valid drops
//    at once; no stale beat appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared widths and beat type for the float normalisation datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fp_pkg;

    localparam int MW       = 24;   // mantissa width, hidden bit included
    localparam int EW       = 8;    // biased exponent width
    localparam int LZW      = 5;    // leading-zero count width, holds 0..MW
    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic          zero;
        logic          uf;
    } norm_beat_t;

endpackage

// File: rtl/fp_lshift.sv
// Barrel left shifter, one mux level per shift-amount bit, zero fill.
// Latency: combinational.
// Backpressure: none (no handshake).
module fp_lshift #(
    parameter int MW  = 24,
    parameter int LZW = 5
) (
    input  logic [MW-1:0]  din,
    input  logic [LZW-1:0] sh,
    output logic [MW-1:0]  dout
);

    logic [MW-1:0] lvl [0:LZW];

    assign lvl[0] = din;

    // Level i shifts by 2**i when bit i of the amount is set; bits past MW fall off.
    for (genvar i = 0; i < LZW; i++) begin : g_lvl
        assign lvl[i+1] = sh[i] ? (lvl[i] << (2**i)) : lvl[i];
    end

    assign dout = lvl[LZW];

endmodule

// File: rtl/fp_norm_shift.sv
// Normalise mantissa using upstream leading-zero count; clamp to subnormal on exponent underflow.
// Latency: 2 cycles from presenting a beat to out_valid, 1 beat/cycle sustained.
// Backpressure: 2-entry pipeline; in_ready = S1 can advance, combinational on out_ready only.
module fp_norm_shift
    import fp_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [MW-1:0]  in_mant,
    input  logic [EW-1:0]  in_exp,
    input  logic [LZW-1:0] in_lz,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [MW-1:0]  out_mant,
    output logic [EW-1:0]  out_exp,
    output logic           out_zero,
    output logic           out_uf
);

    logic           s1_v, s2_v;
    logic           s1_adv, s2_adv;
    norm_beat_t     s1_d, s1_q, s2_d, s2_q;
    logic [LZW-1:0] sh_d, s1_sh;
    logic [EW:0]    e_ext, n_ext;
    logic [MW-1:0]  shifted;

    assign s2_adv   = ~s2_v | out_ready;
    assign s1_adv   = ~s1_v | s2_adv;
    assign in_ready = s1_adv;

    // Shift decision: normalise fully if the exponent allows, otherwise stop at exponent 0.
    always_comb begin
        e_ext     = {1'b0, in_exp};
        n_ext     = {{(EW+1-LZW){1'b0}}, in_lz};
        s1_d.mant = in_mant;
        s1_d.exp  = '0;
        s1_d.zero = 1'b0;
        s1_d.uf   = 1'b0;
        sh_d      = '0;
        if (in_lz == LZW'(MW)) begin
            s1_d.zero = 1'b1;
        end else if (e_ext > n_ext) begin
            sh_d     = in_lz;
            s1_d.exp = in_exp - EW'(in_lz);
        end else if (in_exp != '0) begin
            // e <= n < MW here, so e-1 always fits the shift field
            sh_d    = LZW'(in_exp - EW'(1));
            s1_d.uf = 1'b1;
        end else begin
            s1_d.uf = 1'b1;
        end
    end

    fp_lshift #(.MW(MW), .LZW(LZW)) u_lshift (
        .din  (s1_q.mant),
        .sh   (s1_sh),
        .dout (shifted)
    );

    // S2 input: shifted mantissa, decision results carried through.
    always_comb begin
        s2_d      = s1_q;
        s2_d.mant = shifted;
    end

    // S1 register: loads whenever it can advance; valid follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v  <= 1'b0;
            s1_q  <= '0;
            s1_sh <= '0;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_q  <= s1_d;
                s1_sh <= sh_d;
            end
        end
    end

    // S2 register: holds while downstream stalls a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v <= 1'b0;
            s2_q <= '0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid = s2_v;
    assign out_mant  = s2_q.mant;
    assign out_exp   = s2_q.exp;
    assign out_zero  = s2_q.zero;
    assign out_uf    = s2_q.uf;

endmodule

// File: tb/tb_fp_norm_shift.sv
`timescale 1ps/1ps
module tb_fp_norm_shift;
    import fp_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready, out_valid, out_ready;
    logic [MW-1:0]  in_mant, out_mant;
    logic [EW-1:0]  in_exp, out_exp;
    logic [LZW-1:0] in_lz;
    logic           out_zero, out_uf;

    int n_checks = 0;
    int n_fail   = 0;

    always #500 clk = ~clk;

    fp_norm_shift dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mant(in_mant), .in_exp(in_exp), .in_lz(in_lz),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mant(out_mant), .out_exp(out_exp),
        .out_zero(out_zero), .out_uf(out_uf)
    );

    // Illegal leading-zero counts must never be driven.
    always @(posedge clk) begin
        if (rst_n && in_valid && (in_lz > LZW'(MW))) begin
            n_fail++;
            $display("FAIL illegal_lz: got %0d allowed max %0d", in_lz, MW);
        end
    end

    function automatic logic [LZW-1:0] clz24(input logic [MW-1:0] v);
        clz24 = LZW'(MW);
        for (int i = 0; i < MW; i++) begin
            if (v[i]) clz24 = LZW'(MW - 1 - i);
        end
    endfunction

    // Present one beat into an idle pipe with out_ready=1 and capture output two edges later.
    task automatic send_one(input logic [MW-1:0] m, input logic [EW-1:0] e, input logic [LZW-1:0] n,
                            output logic v, output logic [MW-1:0] om, output logic [EW-1:0] oe,
                            output logic oz, output logic ou);
        in_mant = m; in_exp = e; in_lz = n; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        v = out_valid; om = out_mant; oe = out_exp; oz = out_zero; ou = out_uf;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_exp = '0; in_lz = '0; out_ready = 1'b0;
        #1700;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++;
        if ({out_mant, out_exp, out_zero, out_uf} !== '0) begin
            n_fail++; $display("FAIL reset_data: got mant=%h exp=%0d z=%b uf=%b expected all 0", out_mant, out_exp, out_zero, out_uf);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_vectors();
        logic v, oz, ou; logic [MW-1:0] om; logic [EW-1:0] oe;
        // normal case
        send_one(24'h000400, 8'd100, 5'd13, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'h800000, 8'd87, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL vec_normal: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=800000 exp=87 z=0 uf=0", v, om, oe, oz, ou);
        end
        // underflow to subnormal
        send_one(24'h000001, 8'd5, 5'd23, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'h000010, 8'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL vec_subnormal: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=000010 exp=0 z=0 uf=1", v, om, oe, oz, ou);
        end
        // zero
        send_one(24'h000000, 8'd77, 5'd24, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'h000000, 8'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL vec_zero: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=000000 exp=0 z=1 uf=0", v, om, oe, oz, ou);
        end
        // already normalised, max exponent
        send_one(24'hC00000, 8'd255, 5'd0, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'hC00000, 8'd255, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL vec_max_exp: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=c00000 exp=255 z=0 uf=0", v, om, oe, oz, ou);
        end
    endtask

    task automatic test_boundary();
        logic v, oz, ou; logic [MW-1:0] om; logic [EW-1:0] oe;
        // e == n: shift e-1 = 12, subnormal
        send_one(24'h000400, 8'd13, 5'd13, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'h400000, 8'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL bnd_e_eq_n: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=400000 exp=0 z=0 uf=1", v, om, oe, oz, ou);
        end
        // e == n+1: full normalise, exponent lands on 1
        send_one(24'h000400, 8'd14, 5'd13, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'h800000, 8'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL bnd_e_gt_n: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=800000 exp=1 z=0 uf=0", v, om, oe, oz, ou);
        end
        // e == 0: no shift, already subnormal
        send_one(24'h000400, 8'd0, 5'd13, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'h000400, 8'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL bnd_e_zero: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=000400 exp=0 z=0 uf=1", v, om, oe, oz, ou);
        end
        // e=1, n=23: shift 0, subnormal
        send_one(24'h000001, 8'd1, 5'd23, v, om, oe, oz, ou);
        n_checks++;
        if ({v, om, oe, oz, ou} !== {1'b1, 24'h000001, 8'd0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL bnd_e_one: got v=%b mant=%h exp=%0d z=%b uf=%b expected v=1 mant=000001 exp=0 z=0 uf=1", v, om, oe, oz, ou);
        end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] m [3];
        logic [EW-1:0] e [3];
        logic [LZW-1:0] n [3];
        logic [MW-1:0] xm [3];
        logic [EW-1:0] xe [3];
        m = '{24'h000400, 24'h0000F0, 24'h400000};
        e = '{8'd100,     8'd30,      8'd2};
        n = '{5'd13,      5'd16,      5'd1};
        xm = '{24'h800000, 24'hF00000, 24'h800000};
        xe = '{8'd87,      8'd14,      8'd1};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                in_valid = 1'b1; in_mant = m[k]; in_exp = e[k]; in_lz = n[k];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready); end
            @(posedge clk); #1;
            // beat j appears right after the edge following its transfer edge
            if (k >= 1 && k <= 3) begin
                n_checks++;
                if ({out_valid, out_mant, out_exp} !== {1'b1, xm[k-1], xe[k-1]}) begin
                    n_fail++; $display("FAIL b2b_out[%0d]: got v=%b mant=%h exp=%0d expected v=1 mant=%h exp=%0d", k-1, out_valid, out_mant, out_exp, xm[k-1], xe[k-1]);
                end
            end else begin
                n_checks++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_bubble[%0d]: got v=%b expected 0", k, out_valid); end
            end
        end
    endtask

    task automatic test_stream();
        logic [MW-1:0] xm [40];
        logic [EW-1:0] xe [40];
        logic [15:0] lfsr = 16'hACE1;
        int snd = 0, rcv = 0, cyc = 0, occ;
        logic prev_stall = 1'b0;
        logic [MW-1:0] pm; logic [EW-1:0] pe;
        for (int i = 0; i < 40; i++) begin
            xm[i] = MW'(i + 1) << clz24(MW'(i + 1));
            xe[i] = 8'd50 - EW'(clz24(MW'(i + 1)));
        end
        while (rcv < 40 && cyc < 2000) begin
            if (snd < 40) begin
                in_valid = 1'b1; in_mant = MW'(snd + 1); in_exp = 8'd50; in_lz = clz24(MW'(snd + 1));
            end else begin
                in_valid = 1'b0;
            end
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            out_ready = lfsr[0];
            @(negedge clk);
            occ = snd - rcv;
            n_checks++;
            if (occ > 2) begin n_fail++; $display("FAIL stream_occupancy: got %0d expected <=2", occ); end
            if (!in_ready) begin
                n_checks++;
                if (!(occ == 2 && out_valid && !out_ready)) begin
                    n_fail++; $display("FAIL stream_in_ready_low: got occ=%0d v=%b r=%b expected occ=2 v=1 r=0", occ, out_valid, out_ready);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if ({out_valid, out_mant, out_exp} !== {1'b1, pm, pe}) begin
                    n_fail++; $display("FAIL stream_stall_hold: got v=%b mant=%h exp=%0d expected v=1 mant=%h exp=%0d", out_valid, out_mant, out_exp, pm, pe);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if ({out_mant, out_exp, out_zero, out_uf} !== {xm[rcv], xe[rcv], 1'b0, 1'b0}) begin
                    n_fail++; $display("FAIL stream_beat[%0d]: got mant=%h exp=%0d z=%b uf=%b expected mant=%h exp=%0d z=0 uf=0", rcv, out_mant, out_exp, out_zero, out_uf, xm[rcv], xe[rcv]);
                end
                rcv++;
            end
            prev_stall = out_valid & ~out_ready;
            pm = out_mant; pe = out_exp;
            if (in_valid && in_ready) snd++;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (rcv != 40) begin n_fail++; $display("FAIL stream_count: got %0d beats expected 40", rcv); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_extra_beat: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_mant = 24'h000400; in_exp = 8'd100; in_lz = 5'd13;
        @(posedge clk); #1;
        in_mant = 24'h000001; in_exp = 8'd5; in_lz = 5'd23;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            n_fail++; $display("FAIL rstmid_full: got v=%b in_ready=%b expected v=1 in_ready=0", out_valid, in_ready);
        end
        #200;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_drop: got v=%b expected 0", out_valid); end
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_stale[%0d]: got v=%b expected 0", k, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_boundary();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        test_vectors();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
